// File: rtl/seven_seg_pkg.sv
// Shared definitions for seven-segment display blocks: blanking constants,
// the active-low hex decode table and the display-word layout.
package seven_seg_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Index = hex digit, element bit 0 = segment a, active-low.
    localparam logic [0:6] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // One complete display image: four nibbles, four dps, zero-suppress flag.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
    } disp_word_t;

    function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot timer: counts clk cycles within a digit slot, steps the digit
// index on every slot wrap and flags the blank phase and the frame boundary.
module seg_scan_timer #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       blank,
    output logic [1:0] idx,
    output logic       boundary
);

    localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_DIGIT - 1);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic          wrap;

    generate
        if (TICKS_PER_DIGIT < BLANK_CYCLES + 2) begin : g_bad_ticks
            $error("TICKS_PER_DIGIT must be at least BLANK_CYCLES + 2");
        end
    endgenerate

    assign wrap     = (cnt_reg == CNT_LAST);
    assign idx      = idx_reg;
    assign boundary = wrap && (idx_reg == 2'd3);

    // Slot counter; the 2-bit digit index rolls 3 -> 0 by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (wrap) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // A zero-length blank phase needs no comparator at all.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
            assign blank = (cnt_reg < BLANK_END);
        end
    endgenerate

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit common-anode scanner. New images are staged in a shadow copy
// and committed only at a frame boundary so a frame never mixes two values.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES    = 2000,
    parameter int NUM_DIGITS      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [0:6]  sevenSegment,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    generate
        if (NUM_DIGITS != 4) begin : g_bad_digits
            $error("seven_segment_scanner supports exactly 4 digits");
        end
    endgenerate

    logic       blank;
    logic [1:0] idx;
    logic       boundary;

    disp_word_t incoming;
    disp_word_t shadow_reg;
    disp_word_t active_reg;
    logic       pending_reg;

    logic [3:0] suppress;
    logic [0:6] seg_next;
    logic       dp_next;
    logic [3:0] an_next;

    seg_scan_timer #(
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .BLANK_CYCLES    (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .blank    (blank),
        .idx      (idx),
        .boundary (boundary)
    );

    assign incoming = {value, dp_in, lz_en};

    // Stage loads in the shadow; commit at the boundary, with a load landing
    // on the boundary cycle itself going straight to the active image.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            if (load) begin
                shadow_reg <= incoming;
            end
            if (boundary) begin
                pending_reg <= 1'b0;
                if (load) begin
                    active_reg <= incoming;
                end else if (pending_reg) begin
                    active_reg <= shadow_reg;
                end
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    // A digit is suppressed when it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_units
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = active_reg.lz &&
                                      (active_reg.value[15:4*gi] == '0);
            end
        end
    endgenerate

    // Select anode, segments and dp for the current slot phase.
    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        an_next  = AN_OFF;
        if (!blank) begin
            an_next = ~(4'b0001 << idx);
            dp_next = ~active_reg.dp[idx];
            if (!suppress[idx]) begin
                seg_next = hex_to_seg(active_reg.value[{idx, 2'b00} +: 4]);
            end
        end
    end

    // Register all pin-facing outputs together so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sevenSegment <= SEG_OFF;
            dp           <= 1'b1;
            an           <= AN_OFF;
            frame_tick   <= 1'b0;
        end else begin
            sevenSegment <= seg_next;
            dp           <= dp_next;
            an           <= an_next;
            frame_tick   <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with short slots (8 ticks, 2 blank).
module tb_seven_segment_scanner;

    localparam int TPD   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * TPD;

    localparam logic [0:6] OFF7 = 7'b1111111;
    localparam logic [0:6] SEG_REF [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [0:6]  sevenSegment;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .TICKS_PER_DIGIT (TPD),
        .BLANK_CYCLES    (BLK),
        .NUM_DIGITS      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .value        (value),
        .dp_in        (dp_in),
        .lz_en        (lz_en),
        .sevenSegment (sevenSegment),
        .dp           (dp),
        .an           (an),
        .frame_tick   (frame_tick)
    );

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: time since reset gives slot phase and digit directly;
    // the displayed image changes only at the last cycle of a frame.
    logic        model_valid = 1'b0;
    int          t;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp;
    logic        m_lz, s_lz, m_pend;
    logic [0:6]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_tick;

    always @(posedge clk) begin
        int  ph;
        int  dg;
        bit  bnd;
        logic [3:0] nib;
        if (reset) begin
            model_valid = 1'b1;
            t = 0;
            m_val = '0; m_dp = '0; m_lz = 1'b0;
            s_val = '0; s_dp = '0; s_lz = 1'b0; m_pend = 1'b0;
            e_seg = OFF7; e_dp = 1'b1; e_an = 4'hF; e_tick = 1'b0;
        end else if (model_valid) begin
            ph  = t % TPD;
            dg  = (t / TPD) % 4;
            bnd = ((t % FRAME) == FRAME - 1);
            e_seg = OFF7; e_dp = 1'b1; e_an = 4'hF;
            if (ph >= BLK) begin
                e_an[dg] = 1'b0;
                e_dp = ~m_dp[dg];
                nib  = m_val[4*dg +: 4];
                if (!(m_lz && dg > 0 && (m_val >> (4*dg)) == 16'h0))
                    e_seg = SEG_REF[nib];
            end
            e_tick = bnd;
            if (bnd) begin
                if (load) begin
                    m_val = value; m_dp = dp_in; m_lz = lz_en;
                end else if (m_pend) begin
                    m_val = s_val; m_dp = s_dp; m_lz = s_lz;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) begin
                s_val = value; s_dp = dp_in; s_lz = lz_en;
            end
            t++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_an",   32'(an),           32'(e_an));
            check("model_seg",  32'(sevenSegment), 32'(e_seg));
            check("model_dp",   32'(dp),           32'(e_dp));
            check("model_tick", 32'(frame_tick),   32'(e_tick));
        end
    end

    logic [0:6] cap_seg [4];
    logic       cap_dp  [4];
    int         cap_cnt [4];

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        value = v; dp_in = d; lz_en = lz; load = 1'b1;
        $display("load value=%h dp_in=%b lz_en=%b at %0t", v, d, lz, $time);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick: got no frame_tick required one within 100 cycles");
        end
    endtask

    // Record what each digit shows over the 32 cycles after a frame_tick.
    task automatic capture_frame();
        for (int d = 0; d < 4; d++) begin
            cap_seg[d] = OFF7; cap_dp[d] = 1'b1; cap_cnt[d] = 0;
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (an == ~(4'b0001 << d)) begin
                    cap_seg[d] = sevenSegment;
                    cap_dp[d]  = dp;
                    cap_cnt[d]++;
                end
            end
        end
    endtask

    task automatic check_digit(input string name, input int d,
                               input logic [0:6] seg, input logic dpv);
        check({name, "_seg"}, 32'(cap_seg[d]), 32'(seg));
        check({name, "_dp"},  32'(cap_dp[d]),  32'(dpv));
        check({name, "_cnt"}, 32'(cap_cnt[d]), 32'(TPD - BLK));
    endtask

    initial begin
        int ticks;
        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;

        // 1: reset, then three dark cycles before digit 0 lights
        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("reset released at %0t", $time);
        for (int i = 0; i < 3; i++) begin
            check("t1_an_dark",  32'(an),           32'h0000000F);
            check("t1_seg_dark", 32'(sevenSegment), 32'(7'b1111111));
            @(negedge clk);
        end
        check("t1_an_d0",  32'(an),           32'(4'b1110));
        check("t1_seg_d0", 32'(sevenSegment), 32'(7'b0000001));

        // 2: 12AF with dp on digit 2
        do_load(16'h12AF, 4'b0100, 1'b0);
        wait_tick();
        capture_frame();
        check_digit("t2_d0", 0, 7'b0111000, 1'b1);
        check_digit("t2_d1", 1, 7'b0001000, 1'b1);
        check_digit("t2_d2", 2, 7'b0010010, 1'b0);
        check_digit("t2_d3", 3, 7'b1001111, 1'b1);

        // 3: two loads in one frame, only the last is shown
        do_load(16'h0000, 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        do_load(16'h0009, 4'b0000, 1'b0);
        wait_tick();
        capture_frame();
        check_digit("t3_d0", 0, 7'b0000100, 1'b1);
        check_digit("t3_d1", 1, 7'b0000001, 1'b1);
        check_digit("t3_d3", 3, 7'b0000001, 1'b1);

        // 4: leading-zero suppression, dp on a suppressed digit stays lit
        do_load(16'h0050, 4'b1000, 1'b1);
        wait_tick();
        capture_frame();
        check_digit("t4_d3", 3, 7'b1111111, 1'b0);
        check_digit("t4_d2", 2, 7'b1111111, 1'b1);
        check_digit("t4_d1", 1, 7'b0100100, 1'b1);
        check_digit("t4_d0", 0, 7'b0000001, 1'b1);

        // 5: load exactly on the boundary cycle
        wait_tick();
        repeat (FRAME - 1) @(negedge clk);
        value = 16'hBEEF; dp_in = 4'b0000; lz_en = 1'b0; load = 1'b1;
        $display("load value=%h dp_in=%b lz_en=%b at %0t (boundary)", value, dp_in, lz_en, $time);
        @(negedge clk);
        load = 1'b0;
        check("t5_tick", 32'(frame_tick), 32'd1);
        capture_frame();
        check_digit("t5_d3", 3, 7'b1100000, 1'b1);
        check_digit("t5_d2", 2, 7'b0110000, 1'b1);
        check_digit("t5_d1", 1, 7'b0110000, 1'b1);
        check_digit("t5_d0", 0, 7'b0111000, 1'b1);

        // 6: reset during digit 2 drive phase
        wait_tick();
        repeat (19) @(negedge clk);
        check("t6_an_pre", 32'(an), 32'(4'b1011));
        reset = 1'b1;
        $display("reset asserted mid-frame at %0t", $time);
        @(negedge clk);
        check("t6_an_rst",  32'(an),           32'h0000000F);
        check("t6_seg_rst", 32'(sevenSegment), 32'(7'b1111111));
        @(negedge clk);
        reset = 1'b0;
        ticks = 0;
        for (int j = 1; j < FRAME; j++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
            if (j == 3) begin
                check("t6_an_d0",  32'(an),           32'(4'b1110));
                check("t6_seg_d0", 32'(sevenSegment), 32'(7'b0000001));
            end
        end
        check("t6_no_early_tick", 32'(ticks), 32'd0);
        @(negedge clk);
        check("t6_tick_at_32", 32'(frame_tick), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
